instr_queue: RTL and testbench

//  Instruction queue between decode and issue. Decode enqueues one instr_struct

---
 rtl/instr_queue.sv | 107 ++++++++++
 tb/tb_instr_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Decode-to-issue instruction queue: 4-entry in-order circular buffer,
// first-word-fall-through head, synchronous full flush on mispredict.
//
// Ports:
//   clk_i      rising-edge clock
//   reset_n_i  async active-low reset (drops all entries)
//   flush_i    discard all entries on the next edge (mispredict)
//   valid_i    decode presents data_i; enqueued when valid_i & ready_o
//   ready_o    queue not full
//   data_i     decoded instr_struct word
//   valid_o    head entry valid (queue not empty)
//   data_o     head entry, read combinationally from storage
//   yumi_i     issue consumes the head this cycle (only while valid_o)
//   count_o    occupancy 0..4

package instr_queue_pkg;

    typedef struct packed {
        logic [23:0] op;
        logic [3:0]  branch_id;
        logic [31:0] pc;
    } instr_struct;

endpackage

module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int width_p     = $bits(instr_struct),
    parameter int ptr_width_p = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   flush_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     data_i,
    output logic                   valid_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   yumi_i,
    output logic [ptr_width_p:0]   count_o
);

    localparam int cap_lp = 1 << ptr_width_p;

    // One extra pointer bit separates full from empty when the
    // storage indices coincide.
    typedef logic [ptr_width_p:0] ptr_t;

    logic [width_p-1:0] mem [cap_lp];

    ptr_t wr_ptr;
    ptr_t rd_ptr;

    logic empty;
    logic full;
    logic do_enq;
    logic do_deq;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ptr_width_p] != rd_ptr[ptr_width_p]) &&
                   (wr_ptr[ptr_width_p-1:0] == rd_ptr[ptr_width_p-1:0]);

    assign valid_o = ~empty;
    assign ready_o = ~full;
    assign count_o = wr_ptr - rd_ptr;
    assign data_o  = mem[rd_ptr[ptr_width_p-1:0]];

    // Full blocks enqueue even when the head leaves the same cycle.
    assign do_enq = valid_i & ~full  & ~flush_i;
    assign do_deq = yumi_i  & ~empty & ~flush_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    // Storage is never cleared; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            mem[wr_ptr[ptr_width_p-1:0]] <= data_i;
        end
    end

    a_no_yumi_when_empty: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        !(yumi_i && !valid_o)
    ) else $error("yumi_i asserted while queue empty");

    a_count_in_range: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        count_o <= (ptr_width_p+1)'(cap_lp)
    ) else $error("count_o exceeds capacity");

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: reset, latency, full/back-pressure,
// simultaneous enq/deq, pointer wrap, flush and async reset.

module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int W = $bits(instr_struct);

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic         yumi_i;
    logic [2:0]   count_o;

    int checks   = 0;
    int failures = 0;

    instr_queue dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i),
        .count_o   (count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic instr_struct mk(input logic [31:0] pc);
        instr_struct s;
        s.pc        = pc;
        s.branch_id = pc[5:2];
        s.op        = ~pc[23:0];
        return s;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic enq(input logic [31:0] pc);
        valid_i = 1'b1;
        data_i  = mk(pc);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic deq_chk(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 64'(valid_o), 64'd1);
        chk({tag, "_data"}, 64'(data_o), 64'(mk(pc)));
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
    endtask

    task automatic chk_state(input string tag,
                             input logic [2:0] cnt,
                             input logic v,
                             input logic r);
        chk({tag, "_count"}, 64'(count_o), 64'(cnt));
        chk({tag, "_valid"}, 64'(valid_o), 64'(v));
        chk({tag, "_ready"}, 64'(ready_o), 64'(r));
    endtask

    initial begin
        logic [2:0] cnt_seq [5];
        cnt_seq = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};

        reset_n_i = 1'b0;
        flush_i   = 1'b0;
        valid_i   = 1'b0;
        yumi_i    = 1'b0;
        data_i    = '0;

        // 1: reset state, single entry latency
        #12;
        chk_state("rst", 3'd0, 1'b0, 1'b1);
        reset_n_i = 1'b1;
        tick();
        enq(32'h60);
        chk_state("t1", 3'd1, 1'b1, 1'b1);
        deq_chk("t1_head", 32'h60);
        chk_state("t1_empty", 3'd0, 1'b0, 1'b1);

        // 2: fill, back-pressure, drain
        for (int k = 0; k < 4; k++) enq(32'(4 * k));
        chk_state("t2_full", 3'd4, 1'b1, 1'b0);
        valid_i = 1'b1;
        data_i  = mk(32'h10);
        tick();
        tick();
        chk_state("t2_hold", 3'd4, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t2_head%0d", c), 64'(data_o),
                64'(mk(32'(4 * c))));
            yumi_i = 1'b1;
            tick();
            if (c == 1) valid_i = 1'b0;
            chk($sformatf("t2_cnt%0d", c), 64'(count_o),
                64'(cnt_seq[c]));
        end
        yumi_i = 1'b0;
        chk_state("t2_end", 3'd0, 1'b0, 1'b1);

        // 3: simultaneous enq/deq at count 2
        enq(32'h20);
        enq(32'h24);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t3_head%0d", c), 64'(data_o),
                64'(mk(32'h20 + 32'(4 * c))));
            valid_i = 1'b1;
            yumi_i  = 1'b1;
            data_i  = mk(32'h28 + 32'(4 * c));
            tick();
            chk($sformatf("t3_cnt%0d", c), 64'(count_o), 64'd2);
        end
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        deq_chk("t3_d0", 32'h2C);
        deq_chk("t3_d1", 32'h30);
        chk_state("t3_end", 3'd0, 1'b0, 1'b1);

        // 4: interleave across pointer wrap
        for (int k = 0; k < 4; k++) enq(32'h100 + 32'(4 * k));
        chk_state("t4_full_a", 3'd4, 1'b1, 1'b0);
        deq_chk("t4_a0", 32'h100);
        deq_chk("t4_a1", 32'h104);
        enq(32'h110);
        enq(32'h114);
        chk_state("t4_full_b", 3'd4, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            deq_chk($sformatf("t4_b%0d", k), 32'h108 + 32'(4 * k));
        chk_state("t4_empty_b", 3'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) enq(32'h118 + 32'(4 * k));
        chk_state("t4_full_c", 3'd4, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            deq_chk($sformatf("t4_c%0d", k), 32'h118 + 32'(4 * k));
        chk_state("t4_empty_c", 3'd0, 1'b0, 1'b1);

        // 5: flush overrides concurrent enq/deq
        enq(32'h300);
        enq(32'h304);
        enq(32'h308);
        chk_state("t5_pre", 3'd3, 1'b1, 1'b1);
        flush_i = 1'b1;
        valid_i = 1'b1;
        yumi_i  = 1'b1;
        data_i  = mk(32'h30C);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        chk_state("t5_flush", 3'd0, 1'b0, 1'b1);
        tick();
        chk_state("t5_idle", 3'd0, 1'b0, 1'b1);

        // 6: async reset mid-cycle
        enq(32'h400);
        enq(32'h404);
        chk_state("t6_pre", 3'd2, 1'b1, 1'b1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk_state("t6_rst", 3'd0, 1'b0, 1'b1);
        #2;
        reset_n_i = 1'b1;
        tick();
        enq(32'h200);
        chk_state("t6_post", 3'd1, 1'b1, 1'b1);
        deq_chk("t6_head", 32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
